// File: rtl/sin_dds_pkg.sv
// Shared types, constants and helpers for the differential DDS waveform source.
package sin_dds_pkg;

    typedef enum logic [1:0] {
        SINE   = 2'd0,
        SQUARE = 2'd1,
        TRI    = 2'd2,
        RAMP   = 2'd3
    } wave_mode_e;

    localparam real PI = 3.14159265358979323846;

    // Config fields use the widest supported sizes; consumers cast down to their own widths.
    localparam int CFG_FCW_W   = 32;
    localparam int CFG_PHASE_W = 16;
    localparam int CFG_AMP_W   = 8;

    typedef struct packed {
        logic [CFG_FCW_W-1:0]   fcw;
        logic [CFG_PHASE_W-1:0] phase;
        logic [CFG_AMP_W-1:0]   amp;
    } ch_cfg_t;

    function automatic int lut_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/dds_wave_lut.sv
// Combinational waveform lookup: maps a table address and mode to a value in [-1,1].
module dds_wave_lut
    import sin_dds_pkg::*;
#(
    parameter int LUT_ADDR_W = 8
) (
    input  logic [LUT_ADDR_W-1:0] addr,
    input  wave_mode_e            mode,
    output real                   w
);

    localparam int  DEPTH   = lut_depth(LUT_ADDR_W);
    localparam real DEPTH_R = real'(DEPTH);

    real sin_tab [DEPTH];
    real a_r;

    // Reads no signals, so it settles once at start-up into a constant table.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sin_tab[i] = $sin(2.0 * PI * real'(i) / DEPTH_R);
        end
    end

    always_comb begin
        a_r = real'(addr);
        w   = 0.0;
        case (mode)
            SINE:    w = sin_tab[addr];
            SQUARE:  w = (a_r < DEPTH_R / 2.0) ? 1.0 : -1.0;
            TRI: begin
                if (a_r < DEPTH_R / 4.0)              w = 4.0 * a_r / DEPTH_R;
                else if (a_r < 3.0 * DEPTH_R / 4.0)   w = 2.0 - 4.0 * a_r / DEPTH_R;
                else                                  w = 4.0 * a_r / DEPTH_R - 4.0;
            end
            RAMP:    w = 2.0 * a_r / DEPTH_R - 1.0;
            default: w = 0.0;
        endcase
    end

endmodule

// File: rtl/sin_diff_dds.sv
// Multi-channel clocked differential DDS source: NCO -> waveform lookup -> amplitude/DC scaling,
// with a single-slot config port whose updates apply immediately or at the channel's phase wrap.
module sin_diff_dds
    import sin_dds_pkg::*;
#(
    parameter int  NUM_CH     = 2,
    parameter int  PHASE_W    = 16,
    parameter int  LUT_ADDR_W = 8,
    parameter real SIN_AMP    = 0.5,
    parameter real SIN_DC     = 0.5,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic                  cfg_now,
    input  logic [PHASE_W-1:0]    cfg_fcw,
    input  logic [LUT_ADDR_W-1:0] cfg_phase,
    input  logic [7:0]            cfg_amp,
    output logic [NUM_CH-1:0]     out_valid,
    output real                   sin_vop [NUM_CH],
    output real                   sin_von [NUM_CH]
);

    logic [PHASE_W-1:0]    acc_q   [NUM_CH];
    logic [PHASE_W-1:0]    acc_sum [NUM_CH];
    logic [LUT_ADDR_W-1:0] addr    [NUM_CH];
    logic [NUM_CH-1:0]     carry;
    ch_cfg_t               cfg_q   [NUM_CH];
    real                   w_raw   [NUM_CH];
    real                   w_q     [NUM_CH];

    logic                  pend_q;
    logic [CH_W-1:0]       pend_ch_q;
    ch_cfg_t               pend_cfg_q;
    ch_cfg_t               cfg_in;
    logic                  cfg_acc;
    logic                  ch_ok;
    logic [1:0]            en_pipe_q;

    assign cfg_ready = !pend_q;
    assign out_valid = {NUM_CH{en_pipe_q[1]}};
    assign ch_ok     = int'(cfg_ch) < NUM_CH;
    assign cfg_acc   = cfg_valid && cfg_ready;
    assign cfg_in    = '{fcw: CFG_FCW_W'(cfg_fcw), phase: CFG_PHASE_W'(cfg_phase), amp: cfg_amp};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign {carry[c], acc_sum[c]} = {1'b0, acc_q[c]} + {1'b0, PHASE_W'(cfg_q[c].fcw)};
        assign addr[c] = acc_q[c][PHASE_W-1 -: LUT_ADDR_W] + LUT_ADDR_W'(cfg_q[c].phase);

        dds_wave_lut #(
            .LUT_ADDR_W (LUT_ADDR_W)
        ) u_lut (
            .addr (addr[c]),
            .mode (wave_mode_e'(mode)),
            .w    (w_raw[c])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c]   <= '0;
                cfg_q[c]   <= '{fcw: '0, phase: '0, amp: 8'hFF};
                w_q[c]     <= 0.0;
                sin_vop[c] <= SIN_DC;
                sin_von[c] <= SIN_DC;
            end
            pend_q     <= 1'b0;
            pend_ch_q  <= '0;
            pend_cfg_q <= '0;
            en_pipe_q  <= '0;
        end else begin
            en_pipe_q <= {en_pipe_q[0], en};

            for (int c = 0; c < NUM_CH; c++) begin
                if (en) begin
                    acc_q[c]   <= acc_sum[c];
                    w_q[c]     <= w_raw[c];
                    sin_vop[c] <= SIN_DC + SIN_AMP * (real'(cfg_q[c].amp) / 255.0) * w_q[c];
                    sin_von[c] <= SIN_DC - SIN_AMP * (real'(cfg_q[c].amp) / 255.0) * w_q[c];
                end
            end

            // A deferred update lands with the carry, so the new step starts exactly at phase zero.
            // A zero-fcw channel never carries, so the slot is also drained while paused.
            if (pend_q && (!en || carry[pend_ch_q])) begin
                cfg_q[pend_ch_q] <= pend_cfg_q;
                pend_q           <= 1'b0;
            end

            if (cfg_acc && ch_ok) begin
                if (cfg_now || !en) begin
                    cfg_q[cfg_ch] <= cfg_in;
                end else begin
                    pend_q     <= 1'b1;
                    pend_ch_q  <= cfg_ch;
                    pend_cfg_q <= cfg_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_sin_diff_dds.sv
// Directed bench for sin_diff_dds: reset, sine timing, deferred update, mode/amp, phase offset, reset with pending.
module tb_sin_diff_dds;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [0:0]  cfg_ch;
    logic        cfg_now;
    logic [15:0] cfg_fcw;
    logic [7:0]  cfg_phase;
    logic [7:0]  cfg_amp;
    logic [1:0]  out_valid;
    real         sin_vop [2];
    real         sin_von [2];

    int checks = 0;
    int errors = 0;
    real prev;

    sin_diff_dds #(
        .NUM_CH     (2),
        .PHASE_W    (16),
        .LUT_ADDR_W (8),
        .SIN_AMP    (0.5),
        .SIN_DC     (0.5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_now   (cfg_now),
        .cfg_fcw   (cfg_fcw),
        .cfg_phase (cfg_phase),
        .cfg_amp   (cfg_amp),
        .out_valid (out_valid),
        .sin_vop   (sin_vop),
        .sin_von   (sin_von)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_real(input string tag, input real obs, input real exp);
        real d;
        d = obs - exp;
        if (d < 0.0) d = -d;
        checks++;
        assert (d < 1.0e-3) else begin
            errors++;
            $error("FAIL %s: observed %f expected %f", tag, obs, exp);
        end
    endtask

    task automatic chk_bits(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic ch, input logic now, input logic [15:0] fcw,
                             input logic [7:0] ph, input logic [7:0] amp);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_now   = now;
        cfg_fcw   = fcw;
        cfg_phase = ph;
        cfg_amp   = amp;
        step(1);
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        mode      = 2'd0;
        cfg_valid = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'd0; cfg_valid = 1'b0;
        cfg_ch = 1'b0; cfg_now = 1'b0; cfg_fcw = '0; cfg_phase = '0; cfg_amp = '0;

        // Reset and idle
        step(3);
        chk_real("rst_vop0", sin_vop[0], 0.5);
        chk_real("rst_von0", sin_von[0], 0.5);
        chk_real("rst_vop1", sin_vop[1], 0.5);
        chk_bits("rst_ready", {1'b0, cfg_ready}, 2'b01);
        chk_bits("rst_valid", out_valid, 2'b00);
        rst_n = 1'b1;
        step(2);
        chk_real("idle_vop0", sin_vop[0], 0.5);
        chk_bits("idle_valid", out_valid, 2'b00);

        // Sine, fcw=256 -> one LUT step per clock, period 256
        cfg_write(1'b0, 1'b1, 16'd256, 8'd0, 8'd255);
        en = 1'b1;
        step(1);
        chk_bits("valid_lat1", out_valid, 2'b00);
        step(1);
        chk_bits("valid_lat2", out_valid, 2'b11);
        chk_real("sine_first", sin_vop[0], 0.5);
        for (int k = 3; k <= 66; k++) begin
            step(1);
            chk_real("sine_sum", sin_vop[0] + sin_von[0], 1.0);
        end
        chk_real("sine_peak_vop", sin_vop[0], 1.0);
        chk_real("sine_peak_von", sin_von[0], 0.0);
        chk_real("ch1_idle", sin_vop[1], 0.5);
        step(64);
        chk_real("sine_half", sin_vop[0], 0.5);
        step(64);
        chk_real("sine_trough", sin_vop[0], 0.0);
        step(64);
        chk_real("sine_period", sin_vop[0], 0.5);
        step(1);
        chk_real("sine_step1", sin_vop[0], 0.512271);

        // Deferred fcw=512 requested while acc=0x4000; lands at the wrap to 0x0000
        step(61);
        cfg_write(1'b0, 1'b0, 16'd512, 8'd0, 8'd255);
        chk_bits("defer_ready_low", {1'b0, cfg_ready}, 2'b00);
        step(190);
        chk_bits("defer_ready_prewrap", {1'b0, cfg_ready}, 2'b00);
        step(1);
        chk_bits("defer_ready_back", {1'b0, cfg_ready}, 2'b01);
        step(1);
        chk_real("defer_addr255", sin_vop[0], 0.487729);
        step(2);
        chk_real("defer_addr2", sin_vop[0], 0.524534);
        step(31);
        chk_real("defer_peak", sin_vop[0], 1.0);
        step(64);
        chk_real("defer_trough", sin_vop[0], 0.0);
        step(32);
        chk_real("defer_zero", sin_vop[0], 0.5);
        step(32);
        chk_real("defer_period128", sin_vop[0], 1.0);

        // Phase offset across two channels
        do_reset();
        cfg_write(1'b0, 1'b1, 16'd256, 8'd0, 8'd255);
        cfg_write(1'b1, 1'b1, 16'd256, 8'd64, 8'd255);
        en = 1'b1;
        step(2);
        chk_real("ph_ch0_zero", sin_vop[0], 0.5);
        chk_real("ph_ch1_peak", sin_vop[1], 1.0);
        step(64);
        chk_real("ph_ch0_peak", sin_vop[0], 1.0);
        chk_real("ph_ch1_zero", sin_vop[1], 0.5);
        step(64);
        chk_real("ph_ch0_half", sin_vop[0], 0.5);
        chk_real("ph_ch1_trough", sin_vop[1], 0.0);

        // Pause: outputs hold, out_valid drops after two clocks
        en = 1'b0;
        step(1);
        chk_bits("pause_valid1", out_valid, 2'b11);
        step(1);
        chk_bits("pause_valid2", out_valid, 2'b00);
        chk_real("pause_hold0", sin_vop[0], 0.5);
        chk_real("pause_hold1", sin_vop[1], 0.0);

        // Square at amp=128, resuming from addr 130
        mode = 2'd1;
        cfg_write(1'b0, 1'b1, 16'd256, 8'd0, 8'd128);
        en = 1'b1;
        step(2);
        chk_real("sq_low_vop", sin_vop[0], 0.249020);
        chk_real("sq_low_von", sin_von[0], 0.750980);
        step(125);
        chk_real("sq_low_end", sin_vop[0], 0.249020);
        step(1);
        chk_real("sq_high", sin_vop[0], 0.750980);
        step(127);
        chk_real("sq_high_end", sin_vop[0], 0.750980);
        step(1);
        chk_real("sq_low_again", sin_vop[0], 0.249020);

        // Ramp: rising from addr 130 to 255, then one fall
        mode = 2'd3;
        step(2);
        chk_real("ramp_start", sin_vop[0], 0.503922);
        prev = sin_vop[0];
        for (int j = 259; j <= 383; j++) begin
            step(1);
            chk_bits("ramp_rise", {1'b0, (sin_vop[0] > prev)}, 2'b01);
            prev = sin_vop[0];
        end
        chk_real("ramp_top", sin_vop[0], 0.749020);
        step(1);
        chk_real("ramp_fall", sin_vop[0], 0.249020);

        // Reset while an update is pending
        do_reset();
        cfg_write(1'b0, 1'b1, 16'd256, 8'd0, 8'd255);
        en = 1'b1;
        step(10);
        cfg_write(1'b0, 1'b0, 16'd1000, 8'd0, 8'd255);
        chk_bits("mid_pending", {1'b0, cfg_ready}, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        chk_real("mid_rst_vop", sin_vop[0], 0.5);
        chk_real("mid_rst_von", sin_von[0], 0.5);
        chk_bits("mid_rst_ready", {1'b0, cfg_ready}, 2'b01);
        chk_bits("mid_rst_valid", out_valid, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        step(5);
        chk_real("post_rst_still", sin_vop[0], 0.5);
        chk_bits("post_rst_valid", out_valid, 2'b11);
        chk_bits("post_rst_ready", {1'b0, cfg_ready}, 2'b01);

        // Deferred fcw=0 never wraps; it drains when en drops
        cfg_write(1'b1, 1'b0, 16'd0, 8'd64, 8'd100);
        step(3);
        chk_bits("zero_fcw_pending", {1'b0, cfg_ready}, 2'b00);
        en = 1'b0;
        step(1);
        chk_bits("zero_fcw_applied", {1'b0, cfg_ready}, 2'b01);
        en = 1'b1;
        step(2);
        chk_real("zero_fcw_vop1", sin_vop[1], 0.696078);
        chk_real("zero_fcw_von1", sin_von[1], 0.303922);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
